// File: rtl/ram_step_ctrl.sv
// Single-step RAM access controller: a debounced button press issues one
// write or read cycle; the captured byte is held for the display.
module ram_step_ctrl #(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int RD_LAT     = 1,
  parameter int AW         = 8,
  parameter int DW         = 8
) (
  input  logic          clk_100M,
  input  logic          rst,
  input  logic          btn_step_n,
  input  logic [AW-1:0] sw_addr_n,
  input  logic [DW-1:0] sw_data_n,
  input  logic          sw_wr_n,
  input  logic          sw_inc_n,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_q,
  output logic [DW-1:0] disp_data,
  output logic          busy
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int LW = $clog2(RD_LAT + 2);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    HOLD
  } state_t;

  state_t state, next;

  logic [1:0]    btn_sync;
  logic [1:0]    wr_sync;
  logic [1:0]    inc_sync;
  logic          btn_q;
  logic          deb;
  logic          step;
  logic [CW-1:0] deb_cnt;
  logic          wr_now;
  logic          inc_now;
  logic          op_inc;
  logic          armed;
  logic [AW-1:0] ctr;
  logic [AW-1:0] sel_addr;
  logic [LW-1:0] lat_cnt;

  // Synchronizers idle at the released / read / no-increment levels
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      btn_sync <= 2'b11;
      wr_sync  <= 2'b11;
      inc_sync <= 2'b11;
    end else begin
      btn_sync <= {btn_sync[0], btn_step_n};
      wr_sync  <= {wr_sync[0], sw_wr_n};
      inc_sync <= {inc_sync[0], sw_inc_n};
    end
  end

  assign wr_now  = ~wr_sync[1];
  assign inc_now = ~inc_sync[1];

  // deb holds the accepted level (1 = released); step fires on accepted press
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      btn_q   <= 1'b1;
      deb     <= 1'b1;
      deb_cnt <= '0;
      step    <= 1'b0;
    end else begin
      btn_q <= btn_sync[1];
      step  <= 1'b0;
      if (btn_sync[1] != btn_q) begin
        deb_cnt <= '0;
      end else if (deb_cnt != CW'(DEB_CYCLES - 1)) begin
        deb_cnt <= deb_cnt + 1'b1;
      end else begin
        deb  <= btn_q;
        step <= deb & ~btn_q;
      end
    end
  end

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE: if (step) next = wr_now ? WR : RD;
      WR:   next = HOLD;
      RD:   if (lat_cnt == LW'(RD_LAT)) next = HOLD;
      HOLD: next = IDLE;
    endcase
  end

  always_comb begin
    ram_we = (state == WR);
    busy   = (state != IDLE);
  end

  assign sel_addr = (inc_now && armed) ? ctr : ~sw_addr_n;

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      ram_addr  <= '0;
      ram_din   <= '0;
      disp_data <= '0;
      op_inc    <= 1'b0;
      armed     <= 1'b0;
      ctr       <= '0;
      lat_cnt   <= '0;
    end else begin
      if (!inc_now) armed <= 1'b0;
      unique case (state)
        IDLE: begin
          if (step) begin
            ram_addr <= sel_addr;
            op_inc   <= inc_now;
            lat_cnt  <= '0;
            if (wr_now)  ram_din <= ~sw_data_n;
            if (inc_now) armed   <= 1'b1;
          end
        end
        WR: disp_data <= ram_din;
        RD: begin
          lat_cnt <= lat_cnt + 1'b1;
          if (lat_cnt == LW'(RD_LAT)) disp_data <= ram_q;
        end
        HOLD: if (op_inc) ctr <= ram_addr + 1'b1;
      endcase
    end
  end

endmodule
